// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - VRAM arbiter bus bundle: blanking, MPU port, GPU port, VRAM port, owner
//
// Signals (names follow the display system's pin naming; a leading underscore means active-low):
//   hblank, vblank                              blanking flags from the display controller
//   _mpu_en/_mpu_rd/_mpu_wr/_mpu_be             MPU request strobes and byte enables
//   mpu_addr, mpu_wdata / mpu_rdata, mpu_ack    MPU request payload / response
//   _gpu_en/_gpu_rd/_gpu_wr/_gpu_be             GPU request strobes and byte enables
//   gpu_addr, gpu_wdata / gpu_rdata, gpu_ack    GPU request payload / response
//   _vram_en/_vram_rd/_vram_wr/_vram_be         VRAM strobes and byte enables
//   vram_addr, vram_dout, vram_oe, vram_din     VRAM address, write data, bus drive enable, read data
//   owner                                       current bus owner: 00 none, 01 MPU, 10 GPU
// Modports: slave = arbiter side, master = display/MPU/GPU/VRAM environment side.

interface vram_arbiter_if;
    logic        hblank;
    logic        vblank;

    logic        _mpu_en;
    logic        _mpu_rd;
    logic        _mpu_wr;
    logic [1:0]  _mpu_be;
    logic [15:0] mpu_addr;
    logic [15:0] mpu_wdata;
    logic [15:0] mpu_rdata;
    logic        mpu_ack;

    logic        _gpu_en;
    logic        _gpu_rd;
    logic        _gpu_wr;
    logic [1:0]  _gpu_be;
    logic [15:0] gpu_addr;
    logic [15:0] gpu_wdata;
    logic [15:0] gpu_rdata;
    logic        gpu_ack;

    logic        _vram_en;
    logic        _vram_rd;
    logic        _vram_wr;
    logic [1:0]  _vram_be;
    logic [15:0] vram_addr;
    logic [15:0] vram_dout;
    logic        vram_oe;
    logic [15:0] vram_din;

    logic [1:0]  owner;

    modport slave (
        input  hblank, vblank,
        input  _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr, mpu_wdata,
        output mpu_rdata, mpu_ack,
        input  _gpu_en, _gpu_rd, _gpu_wr, _gpu_be, gpu_addr, gpu_wdata,
        output gpu_rdata, gpu_ack,
        output _vram_en, _vram_rd, _vram_wr, _vram_be, vram_addr, vram_dout, vram_oe,
        input  vram_din,
        output owner
    );

    modport master (
        output hblank, vblank,
        output _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr, mpu_wdata,
        input  mpu_rdata, mpu_ack,
        output _gpu_en, _gpu_rd, _gpu_wr, _gpu_be, gpu_addr, gpu_wdata,
        input  gpu_rdata, gpu_ack,
        input  _vram_en, _vram_rd, _vram_wr, _vram_be, vram_addr, vram_dout, vram_oe,
        output vram_din,
        input  owner
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - two-requester (MPU/GPU) VRAM arbiter with blanking-aware priority
//
// Ports:
//   clk     system clock, all state changes on the rising edge
//   _reset  synchronous active-low reset
//   bus     vram_arbiter_if.slave (requests, responses, VRAM strobes, owner)
// Parameters:
//   ACCESS_CYCLES  VRAM strobe cycles per access (1..15)
//   MAX_WAIT       MPU starvation threshold in IDLE wait cycles (1..255)
// Optional feature macro: VRAM_ARB_STARVE_EN
//   defined   -> MPU wait counter; MPU wins IDLE arbitration once it reaches MAX_WAIT
//   undefined -> pure blanking-based priority
//
// Sequence per access: IDLE (grant, request captured) -> ACCESS x ACCESS_CYCLES -> RELEASE (ack) -> IDLE.

module vram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_WAIT      = 8
) (
    input  logic          clk,
    input  logic          _reset,
    vram_arbiter_if.slave bus
);

    if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
        $error("vram_arbiter: ACCESS_CYCLES out of range 1..15");
    end
    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("vram_arbiter: MAX_WAIT out of range 1..255");
    end

    localparam logic [3:0] LP_LAST_CNT = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_acc_cnt;
    logic        r_sel_gpu;
    logic        r_is_wr;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [1:0]  r_be;
    logic [15:0] r_mpu_rdata;
    logic [15:0] r_gpu_rdata;

    logic        w_mpu_pend;
    logic        w_gpu_pend;
    logic        w_blank;
    logic        w_starved;
    logic        w_mpu_prio;
    logic        w_grant_mpu;
    logic        w_grant_gpu;
    logic        w_grant;
    logic        w_last_acc;

    // A request is only real with exactly one of rd/wr asserted; both or neither is malformed.
    assign w_mpu_pend  = ~bus._mpu_en & (bus._mpu_rd ^ bus._mpu_wr);
    assign w_gpu_pend  = ~bus._gpu_en & (bus._gpu_rd ^ bus._gpu_wr);
    assign w_blank     = bus.hblank | bus.vblank;
    assign w_mpu_prio  = w_blank | w_starved;
    assign w_grant_mpu = (r_state == ST_IDLE) & w_mpu_pend & (w_mpu_prio | ~w_gpu_pend);
    assign w_grant_gpu = (r_state == ST_IDLE) & w_gpu_pend & ~w_grant_mpu;
    assign w_grant     = w_grant_mpu | w_grant_gpu;
    assign w_last_acc  = (r_acc_cnt == LP_LAST_CNT);

`ifdef VRAM_ARB_STARVE_EN
    logic [7:0] r_wait_cnt;

    assign w_starved = (r_wait_cnt >= 8'(MAX_WAIT));

    // Only IDLE cycles count as waiting; saturates so a stuck MPU cannot wrap back to low priority.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            if (!w_mpu_pend || w_grant_mpu) begin
                r_wait_cnt <= 8'd0;
            end else if (r_wait_cnt != 8'hFF) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end
`else
    assign w_starved = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus._vram_en  = 1'b1;
        bus._vram_rd  = 1'b1;
        bus._vram_wr  = 1'b1;
        bus._vram_be  = 2'b11;
        bus.vram_addr = 16'h0000;
        bus.vram_dout = 16'h0000;
        bus.vram_oe   = 1'b0;
        bus.owner     = 2'b00;
        bus.mpu_ack   = 1'b0;
        bus.gpu_ack   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus._vram_en  = 1'b0;
                bus._vram_rd  = r_is_wr;
                bus._vram_wr  = ~r_is_wr;
                bus._vram_be  = r_be;
                bus.vram_addr = r_addr;
                bus.vram_dout = r_wdata;
                bus.vram_oe   = r_is_wr;
                bus.owner     = r_sel_gpu ? 2'b10 : 2'b01;
                if (w_last_acc) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                bus.mpu_ack = ~r_sel_gpu;
                bus.gpu_ack = r_sel_gpu;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture at grant and read-data capture at the end of the last strobe cycle.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_acc_cnt   <= 4'd0;
            r_sel_gpu   <= 1'b0;
            r_is_wr     <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_be        <= 2'b11;
            r_mpu_rdata <= 16'h0000;
            r_gpu_rdata <= 16'h0000;
        end else begin
            if (w_grant) begin
                r_acc_cnt <= 4'd0;
                r_sel_gpu <= w_grant_gpu;
                r_is_wr   <= w_grant_gpu ? ~bus._gpu_wr  : ~bus._mpu_wr;
                r_addr    <= w_grant_gpu ? bus.gpu_addr  : bus.mpu_addr;
                r_wdata   <= w_grant_gpu ? bus.gpu_wdata : bus.mpu_wdata;
                r_be      <= w_grant_gpu ? bus._gpu_be   : bus._mpu_be;
            end
            if (r_state == ST_ACCESS) begin
                r_acc_cnt <= r_acc_cnt + 4'd1;
                if (w_last_acc && !r_is_wr) begin
                    if (r_sel_gpu) begin
                        r_gpu_rdata <= bus.vram_din;
                    end else begin
                        r_mpu_rdata <= bus.vram_din;
                    end
                end
            end
        end
    end

    assign bus.mpu_rdata = r_mpu_rdata;
    assign bus.gpu_rdata = r_gpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter (ACCESS_CYCLES=2, MAX_WAIT=8)

module tb_vram_arbiter;
    logic clk;
    logic _reset;
    int   n_asrt;
    int   n_fail;

    vram_arbiter_if bus ();

    vram_arbiter #(
        .ACCESS_CYCLES(2),
        .MAX_WAIT(8)
    ) dut (
        .clk(clk),
        ._reset(_reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asrt++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, "_en"},   32'(bus._vram_en), 32'h1);
        chk({tag, "_wr"},   32'(bus._vram_wr), 32'h1);
        chk({tag, "_rd"},   32'(bus._vram_rd), 32'h1);
        chk({tag, "_oe"},   32'(bus.vram_oe),  32'h0);
        chk({tag, "_own"},  32'(bus.owner),    32'h0);
    endtask

    task automatic mpu_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata, input logic [1:0] be);
        bus._mpu_en   = 1'b0;
        bus._mpu_wr   = ~wr;
        bus._mpu_rd   = wr;
        bus.mpu_addr  = addr;
        bus.mpu_wdata = wdata;
        bus._mpu_be   = be;
    endtask

    task automatic gpu_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata, input logic [1:0] be);
        bus._gpu_en   = 1'b0;
        bus._gpu_wr   = ~wr;
        bus._gpu_rd   = wr;
        bus.gpu_addr  = addr;
        bus.gpu_wdata = wdata;
        bus._gpu_be   = be;
    endtask

    task automatic mpu_drop;
        bus._mpu_en = 1'b1;
        bus._mpu_rd = 1'b1;
        bus._mpu_wr = 1'b1;
    endtask

    task automatic gpu_drop;
        bus._gpu_en = 1'b1;
        bus._gpu_rd = 1'b1;
        bus._gpu_wr = 1'b1;
    endtask

    initial begin
        int  n_gack;
        bit  got;

        n_asrt = 0;
        n_fail = 0;
        _reset = 1'b0;
        bus.hblank = 1'b0;
        bus.vblank = 1'b0;
        mpu_drop();
        gpu_drop();
        bus._mpu_be = 2'b11; bus.mpu_addr = 16'h0; bus.mpu_wdata = 16'h0;
        bus._gpu_be = 2'b11; bus.gpu_addr = 16'h0; bus.gpu_wdata = 16'h0;
        bus.vram_din = 16'h0;

        // reset state
        tick(); tick();
        chk_bus_idle("rst");
        chk("rst_be",    32'(bus._vram_be),  32'h3);
        chk("rst_addr",  32'(bus.vram_addr), 32'h0);
        chk("rst_dout",  32'(bus.vram_dout), 32'h0);
        chk("rst_mack",  32'(bus.mpu_ack),   32'h0);
        chk("rst_gack",  32'(bus.gpu_ack),   32'h0);
        chk("rst_mrd",   32'(bus.mpu_rdata), 32'h0);
        chk("rst_grd",   32'(bus.gpu_rdata), 32'h0);
        _reset = 1'b1;
        tick();

        // MPU write during blanking: grant cycle 0, strobes cycles 1-2, ack cycle 3
        bus.hblank = 1'b1;
        mpu_req(1'b1, 16'h1234, 16'hBEEF, 2'b00);
        tick();
        chk("w1_own",  32'(bus.owner),     32'h1);
        chk("w1_en",   32'(bus._vram_en),  32'h0);
        chk("w1_wr",   32'(bus._vram_wr),  32'h0);
        chk("w1_rd",   32'(bus._vram_rd),  32'h1);
        chk("w1_be",   32'(bus._vram_be),  32'h0);
        chk("w1_addr", 32'(bus.vram_addr), 32'h1234);
        chk("w1_dout", 32'(bus.vram_dout), 32'hBEEF);
        chk("w1_oe",   32'(bus.vram_oe),   32'h1);
        chk("w1_ack",  32'(bus.mpu_ack),   32'h0);
        mpu_drop();
        bus.mpu_addr = 16'hFFFF;
        tick();
        chk("w2_wr",   32'(bus._vram_wr),  32'h0);
        chk("w2_addr", 32'(bus.vram_addr), 32'h1234);
        chk("w2_ack",  32'(bus.mpu_ack),   32'h0);
        tick();
        chk("w3_mack", 32'(bus.mpu_ack),   32'h1);
        chk("w3_gack", 32'(bus.gpu_ack),   32'h0);
        chk_bus_idle("w3");
        tick();
        chk("w4_mack", 32'(bus.mpu_ack),   32'h0);
        bus.hblank = 1'b0;

        // GPU read during active display
        bus.vram_din = 16'h5A5A;
        gpu_req(1'b0, 16'h0040, 16'h0000, 2'b01);
        tick();
        chk("r1_own",  32'(bus.owner),     32'h2);
        chk("r1_rd",   32'(bus._vram_rd),  32'h0);
        chk("r1_wr",   32'(bus._vram_wr),  32'h1);
        chk("r1_oe",   32'(bus.vram_oe),   32'h0);
        chk("r1_addr", 32'(bus.vram_addr), 32'h0040);
        chk("r1_be",   32'(bus._vram_be),  32'h1);
        gpu_drop();
        tick();
        tick();
        bus.vram_din = 16'h0000;
        chk("r3_gack", 32'(bus.gpu_ack),   32'h1);
        chk("r3_mack", 32'(bus.mpu_ack),   32'h0);
        chk("r3_grd",  32'(bus.gpu_rdata), 32'h5A5A);
        chk("r3_mrd",  32'(bus.mpu_rdata), 32'h0);
        tick();
        chk("r4_grd",  32'(bus.gpu_rdata), 32'h5A5A);
        chk("r4_gack", 32'(bus.gpu_ack),   32'h0);

        // simultaneous requests, active display: GPU first, MPU after one IDLE cycle
        bus.vram_din = 16'hC3C3;
        mpu_req(1'b0, 16'h1000, 16'h0000, 2'b00);
        gpu_req(1'b1, 16'h2000, 16'h1111, 2'b00);
        tick();
        chk("c1_own",  32'(bus.owner),     32'h2);
        chk("c1_addr", 32'(bus.vram_addr), 32'h2000);
        gpu_drop();
        tick(); tick();
        chk("c3_gack", 32'(bus.gpu_ack),   32'h1);
        chk("c3_mack", 32'(bus.mpu_ack),   32'h0);
        tick();
        chk_bus_idle("c4");
        tick();
        chk("c5_own",  32'(bus.owner),     32'h1);
        chk("c5_addr", 32'(bus.vram_addr), 32'h1000);
        mpu_drop();
        tick(); tick();
        chk("c7_mack", 32'(bus.mpu_ack),   32'h1);
        chk("c7_mrd",  32'(bus.mpu_rdata), 32'hC3C3);
        chk("c7_grd",  32'(bus.gpu_rdata), 32'h5A5A);
        tick();

        // simultaneous requests during vblank: MPU first
        bus.vblank = 1'b1;
        mpu_req(1'b1, 16'h3000, 16'h2222, 2'b00);
        gpu_req(1'b0, 16'h4000, 16'h0000, 2'b00);
        tick();
        chk("v1_own",  32'(bus.owner),     32'h1);
        chk("v1_addr", 32'(bus.vram_addr), 32'h3000);
        mpu_drop();
        tick(); tick();
        chk("v3_mack", 32'(bus.mpu_ack),   32'h1);
        tick(); tick();
        chk("v5_own",  32'(bus.owner),     32'h2);
        chk("v5_addr", 32'(bus.vram_addr), 32'h4000);
        gpu_drop();
        tick(); tick();
        chk("v7_gack", 32'(bus.gpu_ack),   32'h1);
        tick();
        bus.vblank = 1'b0;

        // malformed requests are ignored
        bus.hblank = 1'b1;
        bus._mpu_en = 1'b0; bus._mpu_rd = 1'b0; bus._mpu_wr = 1'b0;
        tick(); tick();
        chk("bad_both", 32'(bus.owner), 32'h0);
        bus._mpu_rd = 1'b1; bus._mpu_wr = 1'b1;
        tick(); tick();
        chk("bad_none", 32'(bus.owner), 32'h0);
        mpu_drop();

        // reset in the second ACCESS cycle aborts with no ack
        mpu_req(1'b1, 16'h5555, 16'hAAAA, 2'b00);
        tick();
        chk("a1_own", 32'(bus.owner), 32'h1);
        tick();
        chk("a2_wr",  32'(bus._vram_wr), 32'h0);
        _reset = 1'b0;
        mpu_drop();
        tick();
        chk_bus_idle("a3");
        chk("a3_mack", 32'(bus.mpu_ack),   32'h0);
        chk("a3_addr", 32'(bus.vram_addr), 32'h0);
        chk("a3_mrd",  32'(bus.mpu_rdata), 32'h0);
        _reset = 1'b1;
        tick();
        chk("a4_mack", 32'(bus.mpu_ack), 32'h0);
        chk("a4_own",  32'(bus.owner),   32'h0);
        bus.hblank = 1'b0;
        tick();

        // continuous GPU traffic with MPU pending in active display
        mpu_req(1'b0, 16'h6000, 16'h0000, 2'b00);
        gpu_req(1'b0, 16'h7000, 16'h0000, 2'b00);
        n_gack = 0;
        got = 1'b0;
`ifdef VRAM_ARB_STARVE_EN
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (bus.gpu_ack === 1'b1) n_gack++;
            if (bus.owner === 2'b01) got = 1'b1;
        end
        chk("starve_grant",    32'(got),    32'h1);
        chk("starve_gpu_acks", 32'(n_gack), 32'd8);
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.gpu_ack === 1'b1) n_gack++;
            if (bus.owner === 2'b01) got = 1'b1;
        end
        chk("nostarve_grant",    32'(got),    32'h0);
        chk("nostarve_gpu_acks", 32'(n_gack), 32'd10);
        bus.hblank = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (bus.owner === 2'b01) got = 1'b1;
        end
        chk("blank_grant", 32'(got), 32'h1);
`endif
        mpu_drop();
        gpu_drop();
        for (int i = 0; i < 6; i++) tick();
        chk_bus_idle("end");
        chk("end_mack", 32'(bus.mpu_ack), 32'h0);
        chk("end_gack", 32'(bus.gpu_ack), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
